alu_pipe: RTL and testbench

Parametrised, two-stage pipelined ALU for the datapath. It implements the 16-function logic set (M=0) and a 74181-style arithmetic subset (M=1) at width W, with a valid/ready handshake on both sides. An internal accumulator and a stored carry flag allow chained and multi-word arithmetic without external glue. It is the W-bit, registered successor of the 4-bit combinational ALU4.

---
 rtl/alu_pipe.sv | 157 +++++++++++++++
 tb/tb_alu_pipe.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// Two-stage pipelined W-bit ALU: 16 logic functions plus 74181-style add/sub/inc/dec,
// valid/ready on both sides, with an internal accumulator and stored carry flag for chaining.
module alu_pipe #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    input  logic         M,
    input  logic [3:0]   S,
    input  logic         use_acc,
    input  logic         use_cflag,
    input  logic         wr_acc,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] dout,
    output logic         co,
    output logic         V,
    output logic         Z,
    output logic         N,
    output logic         err,
    output logic [W-1:0] acc
);

    localparam int unsigned SW = W + 1;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         m;
        logic [3:0]   s;
        logic         use_acc;
        logic         use_cflag;
        logic         wr_acc;
    } s1_t;

    s1_t  s1_q;
    logic s1_valid;
    logic cflag;

    logic s2_adv;
    logic s1_adv;
    logic in_fire;

    logic [W-1:0]  a_eff;
    logic          c_eff;
    logic [W-1:0]  bp;
    logic [SW-1:0] sum;
    logic          arith;
    logic [W-1:0]  res_c;
    logic          co_c;
    logic          v_c;
    logic          err_c;

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = s1_valid && s2_adv;
    assign in_ready = rst_n && (!s1_valid || s2_adv);
    assign in_fire  = in_valid && in_ready;

    // Result of the op sitting in S1, using the live accumulator / carry flag
    always_comb begin
        a_eff = s1_q.use_acc ? acc : s1_q.a;
        c_eff = s1_q.use_cflag ? cflag : s1_q.cin;
        bp    = '0;
        sum   = '0;
        arith = 1'b0;
        res_c = '0;
        co_c  = 1'b0;
        v_c   = 1'b0;
        err_c = 1'b0;
        if (!s1_q.m) begin
            case (s1_q.s)
                4'd0:    res_c = '0;
                4'd1:    res_c = ~(a_eff | s1_q.b);
                4'd2:    res_c = ~a_eff & s1_q.b;
                4'd3:    res_c = ~a_eff;
                4'd4:    res_c = a_eff & ~s1_q.b;
                4'd5:    res_c = ~s1_q.b;
                4'd6:    res_c = a_eff ^ s1_q.b;
                4'd7:    res_c = ~(a_eff & s1_q.b);
                4'd8:    res_c = a_eff & s1_q.b;
                4'd9:    res_c = ~(a_eff ^ s1_q.b);
                4'd10:   res_c = s1_q.b;
                4'd11:   res_c = ~a_eff | s1_q.b;
                4'd12:   res_c = a_eff;
                4'd13:   res_c = a_eff | ~s1_q.b;
                4'd14:   res_c = a_eff | s1_q.b;
                default: res_c = '1;
            endcase
        end else begin
            case (s1_q.s)
                4'b1001: begin bp = s1_q.b;  arith = 1'b1; end
                4'b0110: begin bp = ~s1_q.b; arith = 1'b1; end
                4'b0000: begin bp = '0;      arith = 1'b1; end
                4'b1111: begin bp = '1;      arith = 1'b1; end
                default: err_c = 1'b1;
            endcase
            if (arith) begin
                sum   = {1'b0, a_eff} + {1'b0, bp} + SW'(c_eff);
                res_c = sum[W-1:0];
                co_c  = sum[W];
                v_c   = (a_eff[W-1] == bp[W-1]) && (res_c[W-1] != a_eff[W-1]);
            end
        end
    end

    // Stage 1 capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else if (in_fire) begin
            s1_valid <= 1'b1;
            s1_q     <= '{a: a, b: b, cin: cin, m: M, s: S, use_acc: use_acc,
                          use_cflag: use_cflag, wr_acc: wr_acc};
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    // Stage 2 result registers plus accumulator / carry flag, all moving on the S1->S2 transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            dout      <= '0;
            co        <= 1'b0;
            V         <= 1'b0;
            Z         <= 1'b0;
            N         <= 1'b0;
            err       <= 1'b0;
            acc       <= '0;
            cflag     <= 1'b0;
        end else if (s1_adv) begin
            out_valid <= 1'b1;
            dout      <= res_c;
            co        <= co_c;
            V         <= v_c;
            Z         <= (res_c == '0);
            N         <= res_c[W-1];
            err       <= err_c;
            if (s1_q.wr_acc && !err_c) begin
                acc <= res_c;
            end
            if (arith) begin
                cflag <= co_c;
            end
        end else if (s2_adv) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe (W=8): table of directed ops with expected results checked
// through an in-order scoreboard, plus backpressure, accumulator and reset sequences.
module tb_alu_pipe;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] a = '0, b = '0;
    logic       cin = 1'b0, M = 1'b0;
    logic [3:0] S = '0;
    logic       use_acc = 1'b0, use_cflag = 1'b0, wr_acc = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] dout;
    logic       co, V, Z, N, err;
    logic [7:0] acc;

    alu_pipe #(.W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .M(M), .S(S), .use_acc(use_acc),
        .use_cflag(use_cflag), .wr_acc(wr_acc), .out_valid(out_valid),
        .out_ready(out_ready), .dout(dout), .co(co), .V(V), .Z(Z), .N(N),
        .err(err), .acc(acc)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] d;
        logic       co, v, z, n, err;
    } res_t;

    typedef struct {
        logic [7:0] a, b;
        logic       cin, m;
        logic [3:0] s;
        logic       ua, uc, wa;
        res_t       exp;
    } vec_t;

    res_t q[$];
    vec_t vecs[$];
    int   n_checks = 0;
    int   n_pass = 0;
    int   n_accept = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic [7:0] av, input logic [7:0] bv, input logic c,
                                input logic m, input logic [3:0] s, input logic ua,
                                input logic uc, input logic wa, input logic [7:0] d,
                                input logic e_co, input logic e_v, input logic e_z,
                                input logic e_n, input logic e_err);
        vec_t v;
        v.a = av; v.b = bv; v.cin = c; v.m = m; v.s = s;
        v.ua = ua; v.uc = uc; v.wa = wa;
        v.exp = '{d: d, co: e_co, v: e_v, z: e_z, n: e_n, err: e_err};
        return v;
    endfunction

    function automatic res_t add_exp(input logic [7:0] x, input logic [7:0] y, input logic c);
        logic [8:0] s9;
        res_t r;
        s9 = {1'b0, x} + {1'b0, y} + 9'(c);
        r.d = s9[7:0];
        r.co = s9[8];
        r.v = (x[7] == y[7]) && (s9[7] != x[7]);
        r.z = (s9[7:0] == 8'h00);
        r.n = s9[7];
        r.err = 1'b0;
        return r;
    endfunction

    // Offer one op at a negedge; push its expectation when the handshake will complete
    task automatic send(input vec_t v);
        int  waited = 0;
        bit  done = 0;
        @(negedge clk);
        a = v.a; b = v.b; cin = v.cin; M = v.m; S = v.s;
        use_acc = v.ua; use_cflag = v.uc; wr_acc = v.wa;
        in_valid = 1'b1;
        while (!done) begin
            #1;
            if (in_ready) begin
                q.push_back(v.exp);
                n_accept++;
                @(posedge clk);
                done = 1;
            end else if (waited > 50) begin
                chk("accept_timeout", 32'd0, 32'd1);
                in_valid = 1'b0;
                done = 1;
            end else begin
                waited++;
                @(negedge clk);
            end
        end
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        use_acc = 1'b0; use_cflag = 1'b0; wr_acc = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || out_valid) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("drain_timeout", 32'(q.size()), 32'd0);
    endtask

    // Scoreboard: compare every consumed result against the oldest expectation
    always begin
        @(negedge clk);
        #3;
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_result", 32'(dout), 32'hFFFF_FFFF);
            end else begin
                res_t e;
                e = q.pop_front();
                chk("result{do,co,V,Z,N,err}", 32'({dout, co, V, Z, N, err}), 32'(e));
            end
        end
    end

    logic [7:0] ls_do [16];

    initial begin
        ls_do = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77,
                  8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};

        // Reset state
        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_acc", 32'(acc), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("in_ready_after_rst", 32'(in_ready), 32'd1);

        for (int i = 0; i < 16; i++) begin
            vecs.push_back(mk(8'hCC, 8'hAA, 1'b0, 1'b0, 4'(i), 0, 0, 0, ls_do[i],
                              1'b0, 1'b0, (i == 0), ls_do[i][7], 1'b0));
        end
        vecs.push_back(mk(8'h7F, 8'h01, 0, 1, 4'b1001, 0, 0, 0, 8'h80, 0, 1, 0, 1, 0));
        vecs.push_back(mk(8'hC0, 8'hA0, 0, 1, 4'b1001, 0, 0, 0, 8'h60, 1, 1, 0, 0, 0));
        vecs.push_back(mk(8'h0C, 8'h0A, 1, 1, 4'b0110, 0, 0, 0, 8'h02, 1, 0, 0, 0, 0));
        vecs.push_back(mk(8'h0A, 8'h0C, 1, 1, 4'b0110, 0, 0, 0, 8'hFE, 0, 0, 0, 1, 0));
        vecs.push_back(mk(8'h00, 8'h55, 0, 1, 4'b1111, 0, 0, 0, 8'hFF, 0, 0, 0, 1, 0));
        // 16-bit 0x00FF + 0x0001 across two words
        vecs.push_back(mk(8'hFF, 8'h01, 0, 1, 4'b1001, 0, 0, 0, 8'h00, 1, 0, 1, 0, 0));
        vecs.push_back(mk(8'h00, 8'h00, 0, 1, 4'b1001, 0, 1, 0, 8'h01, 0, 0, 0, 0, 0));
        // Accumulator chain, back-to-back
        vecs.push_back(mk(8'h05, 8'h00, 1, 1, 4'b0000, 0, 0, 1, 8'h06, 0, 0, 0, 0, 0));
        vecs.push_back(mk(8'hEE, 8'h10, 0, 1, 4'b1001, 1, 0, 1, 8'h16, 0, 0, 0, 0, 0));
        vecs.push_back(mk(8'h77, 8'h33, 0, 1, 4'b0011, 0, 0, 1, 8'h00, 0, 0, 1, 0, 1));

        foreach (vecs[i]) send(vecs[i]);
        idle();
        drain();
        chk("acc_after_chain", 32'(acc), 32'h16);

        // Backpressure: 6 adds against a 4-cycle stall
        n_accept = 0;
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    vec_t v;
                    v = mk(8'(i * 8'h30), 8'(8'h20 + i * 8'h10), 0, 1, 4'b1001, 0, 0, 0,
                           8'h00, 0, 0, 0, 0, 0);
                    v.exp = add_exp(v.a, v.b, 1'b0);
                    send(v);
                end
                idle();
            end
            begin
                repeat (4) @(negedge clk);
                chk("bp_accepts", 32'(n_accept), 32'd2);
                chk("bp_in_ready_low", 32'(in_ready), 32'd0);
                chk("bp_do_held", 32'(dout), 32'h20);
                out_ready = 1'b1;
            end
        join
        drain();
        chk("bp_total_accepts", 32'(n_accept), 32'd6);

        // Reset with both stages full
        out_ready = 1'b0;
        send(mk(8'h01, 8'h01, 0, 1, 4'b1001, 0, 0, 1, 8'h02, 0, 0, 0, 0, 0));
        send(mk(8'h03, 8'h01, 0, 1, 4'b1001, 0, 0, 1, 8'h04, 0, 0, 0, 0, 0));
        idle();
        chk("full_out_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_do", 32'(dout), 32'd0);
        chk("midrst_acc", 32'(acc), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        send(mk(8'h10, 8'h20, 1, 1, 4'b1001, 0, 0, 0, 8'h31, 0, 0, 0, 0, 0));
        idle();
        #1;
        chk("lat_not_yet", 32'(out_valid), 32'd0);
        @(negedge clk);
        #1;
        chk("lat_2cyc", 32'(out_valid), 32'd1);
        drain();
        chk("rst_no_stale", 32'(q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
